// File: rtl/data_ram_port.sv
// data_ram_port: data-side memory responder with fixed wait states and byte-lane writes
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ce_i, we_i          access request and direction (1 = write)
//   addr_i              byte address; word index is addr_i[ADDR_W+1:2]
//   sel_i               big-endian byte-lane enables (sel_i[3] -> data[31:24])
//   data_i              lane-replicated write data
//   data_o              registered read word, held until the next read completes
//   stall_req           combinational stall request, low only in the completion cycle
//   ack_o               one-cycle completion pulse
module data_ram_port #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_req,
    output logic        ack_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic              req_we;
    logic [ADDR_W-1:0] req_idx;
    logic [3:0]        req_sel;
    logic [31:0]       req_data;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              do_acc;
    logic              unused_addr;

    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
    // The access edge is the last WAIT cycle with ce_i still high; dropping ce_i aborts it.
    assign do_acc    = (state == WAIT) && ce_i && (cnt == 3'd0);
    assign stall_req = ce_i && (state != DONE);
    assign ack_o     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            data_o   <= 32'h0;
            req_we   <= 1'b0;
            req_idx  <= '0;
            req_sel  <= 4'h0;
            req_data <= 32'h0;
        end else if (state == IDLE) begin
            if (ce_i) begin
                state    <= WAIT;
                cnt      <= 3'(WAIT_CYCLES);
                req_we   <= we_i;
                req_idx  <= addr_i[ADDR_W+1:2];
                req_sel  <= sel_i;
                req_data <= data_i;
            end
        end else if (state == WAIT) begin
            if (!ce_i) begin
                state <= IDLE;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end else begin
                state <= DONE;
                if (!req_we) data_o <= mem[req_idx];
            end
        end else begin
            state <= IDLE;
        end
    end

    // Array is never reset; the !rst term keeps a write from landing on a reset edge.
    always_ff @(posedge clk) begin
        if (do_acc && req_we && !rst)
            for (int k = 0; k < 4; k++)
                if (req_sel[k]) mem[req_idx][8*k +: 8] <= req_data[8*k +: 8];
    end
endmodule

// File: tb/tb_data_ram_port.sv
// tb_data_ram_port: randomized scoreboard bench for data_ram_port
module tb_data_ram_port;
    localparam int AW = 10;
    localparam int W  = 2;

    logic        clk = 0, rst = 1;
    logic        ce = 0, we = 0;
    logic [31:0] addr = 0, din = 0;
    logic [3:0]  sel = 0;
    logic [31:0] dout;
    logic        stall, ack;

    logic        ce0 = 0, we0 = 0;
    logic [31:0] addr0 = 0, din0 = 0;
    logic [3:0]  sel0 = 0;
    logic [31:0] dout0;
    logic        stall0, ack0;

    data_ram_port #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(din), .data_o(dout), .stall_req(stall), .ack_o(ack));

    data_ram_port #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we0), .addr_i(addr0), .sel_i(sel0),
        .data_i(din0), .data_o(dout0), .stall_req(stall0), .ack_o(ack0));

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    logic [31:0] mem_m [0:(1<<AW)-1];
    bit          known [0:(1<<AW)-1];
    logic [31:0] last_rd = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        for (int off = 0; off < 4; off++)
            if (s[3-off]) old[31-8*off -: 8] = d[31-8*off -: 8];
        return old;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    always @(negedge clk) begin
        if (ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with data %h, want no ack", dout);
            end else begin
                chk("data_o_at_ack", dout, exp_q.pop_front());
            end
        end
    end

    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int idx = widx(a);
        int n = 0;
        if (w) begin
            mem_m[idx] = merge(mem_m[idx], d, s);
            known[idx] = 1;
        end else begin
            last_rd = mem_m[idx];
        end
        exp_q.push_back(last_rd);
        ce = 1; we = w; addr = a; sel = s; din = d;
        forever begin
            @(negedge clk);
            if (ack || n > W + 4) break;
            chk("stall_during_access", 32'(stall), 32'd1);
            n++;
        end
        chk("latency", 32'(n), 32'(W + 2));
        chk("stall_at_ack", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ce = 0;
    endtask

    task automatic abort_acc(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int k);
        ce = 1; we = w; addr = a; sel = s; din = d;
        repeat (k) @(posedge clk);
        #1 ce = 0;
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_after_abort", 32'(ack), 32'd0);
            chk("no_stall_after_abort", 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_during(input logic w, input logic [31:0] a, input logic [31:0] d, input int cyc);
        ce = 1; we = w; addr = a; sel = 4'hF; din = d;
        repeat (cyc + 1) @(negedge clk);
        chk("data_o_before_reset", dout, last_rd);
        #3 rst = 1;
        #1;
        chk("async_reset_data_o", dout, 32'h0);
        chk("async_reset_ack", 32'(ack), 32'd0);
        last_rd = 0;
        @(posedge clk); #1;
        ce = 0;
        @(negedge clk);
        chk("reset_hold_data_o", dout, 32'h0);
        rst = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int idx;
        #1;
        chk("reset_data_o", dout, 32'h0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_stall_ce0", 32'(stall), 32'd0);
        ce = 1;
        #1 chk("reset_stall_ce1", 32'(stall), 32'd1);
        ce = 0;
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        access(1, 32'h10, 4'hF, 32'hDEADBEEF);
        access(0, 32'h10, 4'hF, 32'h0);
        chk("sw_lw", dout, 32'hDEADBEEF);

        access(1, 32'h20, 4'hF, 32'h11223344);
        access(1, 32'h20, 4'b0100, 32'hAAAAAAAA);
        access(0, 32'h20, 4'hF, 32'h0);
        chk("sb_merge", dout, 32'h11AA3344);
        access(1, 32'h20, 4'b0011, 32'h55665566);
        access(0, 32'h20, 4'hF, 32'h0);
        chk("sh_merge", dout, 32'h11AA5566);
        access(1, 32'h20, 4'b0000, 32'hFFFFFFFF);
        access(0, 32'h20, 4'hF, 32'h0);
        chk("sel0_no_write", dout, 32'h11AA5566);

        access(1, 32'h30, 4'hF, 32'h0);
        abort_acc(1, 32'h30, 4'hF, 32'h12345678, 2);
        access(0, 32'h30, 4'hF, 32'h0);
        chk("abort_no_write", dout, 32'h0);
        abort_acc(1, 32'h10, 4'hF, 32'hBAD0BAD0, W + 1);
        access(0, 32'h10, 4'hF, 32'h0);
        chk("abort_at_cnt0", dout, 32'hDEADBEEF);

        access(1, 32'h4, 4'hF, 32'hCAFEF00D);
        access(0, 32'h1004, 4'hF, 32'h0);
        chk("alias_high", dout, 32'hCAFEF00D);
        access(0, 32'h7, 4'hF, 32'h0);
        chk("alias_offset", dout, 32'hCAFEF00D);

        access(1, 32'h40, 4'hF, 32'h0000BEEF);
        access(0, 32'h40, 4'hF, 32'h0);
        reset_during(0, 32'h40, 32'h0, 1);
        reset_during(1, 32'h40, 32'hFFFFFFFF, W + 1);
        access(0, 32'h40, 4'hF, 32'h0);
        chk("reset_kills_write", dout, 32'h0000BEEF);

        for (int i = 0; i < 200; i++) begin
            idx = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFFF000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                abort_acc(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(1, W + 1));
            else if (!known[widx(a)] || $urandom_range(0, 1) == 1)
                access(1, a, 4'($urandom), $urandom);
            else
                access(0, a, 4'($urandom), 32'h0);
        end

        ce0 = 1; we0 = 1; addr0 = 32'h100; sel0 = 4'hF; din0 = 32'h13579BDF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("wc0_stall", 32'(stall0), (c == 2 || c == 5) ? 32'd0 : 32'd1);
            chk("wc0_ack", 32'(ack0), (c == 2 || c == 5) ? 32'd1 : 32'd0);
            if (c == 5) chk("wc0_data", dout0, 32'h13579BDF);
            if (c == 2) begin
                @(posedge clk); #1;
                we0 = 0; din0 = 0;
            end
        end
        @(posedge clk); #1;
        ce0 = 0;
        @(negedge clk);
        chk("wc0_idle_ack", 32'(ack0), 32'd0);
        chk("wc0_idle_stall", 32'(stall0), 32'd0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
